// File: rtl/div_param.sv
// div_param: parametrised radix-2 restoring divider behind a start/ok handshake.
// Produces one quotient bit per clock. Signed operation works on magnitudes
// and fixes the signs in one extra cycle. Divide-by-zero and the signed
// MIN / -1 overflow case finish in one cycle with fixed results.
module div_param #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             qneg;
    logic             rneg;
    logic [CW-1:0]    cnt;

    logic             eff_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] amag_in;
    logic [WIDTH-1:0] bmag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Operand magnitudes at acceptance and the trial subtraction for one step.
    always_comb begin
        eff_signed = signed_mode & SIGNED_EN;
        a_neg      = eff_signed & A[WIDTH-1];
        b_neg      = eff_signed & B[WIDTH-1];
        amag_in    = a_neg ? ('0 - A) : A;
        bmag_in    = b_neg ? ('0 - B) : B;
        shifted    = {rem, quo[WIDTH-1]};
        trial      = shifted - {1'b0, bmag};
    end

    // Control FSM and datapath; all outputs are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            D     <= '0;
            R     <= '0;
            ok    <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            bmag  <= '0;
            rem   <= '0;
            quo   <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            cnt   <= '0;
        end else begin
            ok  <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        qneg <= a_neg ^ b_neg;
                        rneg <= a_neg;
                        if (B == '0) begin
                            D     <= '1;
                            R     <= A;
                            ok    <= 1'b1;
                            err   <= 1'b1;
                            state <= DONE;
                        end else if (eff_signed && A == MINV && B == '1) begin
                            D     <= MINV;
                            R     <= '0;
                            ok    <= 1'b1;
                            state <= DONE;
                        end else begin
                            rem   <= '0;
                            quo   <= amag_in;
                            bmag  <= bmag_in;
                            cnt   <= CW'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // The dividend shifts out of quo's top as quotient bits shift in.
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                    end
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    D     <= qneg ? ('0 - quo) : quo;
                    R     <= rneg ? ('0 - rem) : rem;
                    ok    <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_param.sv
// tb_div_param: randomized and directed checks of div_param against a
// behavioural model (arithmetic division plus a cycle countdown), for a
// 32-bit signed-capable instance and an 8-bit unsigned-only instance.
module tb_div_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        tst[2];
    logic        tsm[2];
    logic [63:0] ta[2];
    logic [63:0] tbv[2];

    logic [31:0] d32, r32;
    logic        ok32, err32, busy32;
    logic [7:0]  d8, r8;
    logic        ok8, err8, busy8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_param #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .reset(reset), .start(tst[0]), .signed_mode(tsm[0]),
        .A(ta[0][31:0]), .B(tbv[0][31:0]), .D(d32), .R(r32),
        .ok(ok32), .err(err32), .busy(busy32)
    );

    div_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .reset(reset), .start(tst[1]), .signed_mode(tsm[1]),
        .A(ta[1][7:0]), .B(tbv[1][7:0]), .D(d8), .R(r8),
        .ok(ok8), .err(err8), .busy(busy8)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic; fast=1 when the result is immediate.
    function automatic void model_div(input int w, input bit sgn,
                                      input logic [63:0] a_in, input logic [63:0] b_in,
                                      output logic [63:0] q, output logic [63:0] r,
                                      output bit e, output bit fast);
        logic [63:0] mask, a, b, minv;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        minv = 64'd1 << (w - 1);
        a = a_in & mask;
        b = b_in & mask;
        e = 1'b0;
        fast = 1'b0;
        if (b == 64'd0) begin
            q = mask; r = a; e = 1'b1; fast = 1'b1;
        end else if (sgn && a == minv && b == mask) begin
            q = minv; r = 64'd0; fast = 1'b1;
        end else if (sgn) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Cycle-level model: left = edges remaining until the unit is idle again.
    int          left[2];
    logic        eok[2], eerr[2], ebusy[2];
    logic [63:0] ed[2], er[2], pq[2], pr[2];
    int          m_w;
    bit          m_sgn, m_e, m_fast;
    logic [63:0] m_q, m_r;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                left[i] = 0; eok[i] = 0; eerr[i] = 0; ebusy[i] = 0;
                ed[i] = '0; er[i] = '0; pq[i] = '0; pr[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_w   = (i == 0) ? 32 : 8;
                m_sgn = tsm[i] & (i == 0);
                if (left[i] == 0) begin
                    eok[i] = 0; eerr[i] = 0; ebusy[i] = 0;
                    if (tst[i]) begin
                        model_div(m_w, m_sgn, ta[i], tbv[i], m_q, m_r, m_e, m_fast);
                        ebusy[i] = 1;
                        if (m_fast) begin
                            left[i] = 1; eok[i] = 1; eerr[i] = m_e;
                            ed[i] = m_q; er[i] = m_r;
                        end else begin
                            left[i] = m_w + 2; pq[i] = m_q; pr[i] = m_r;
                        end
                    end
                end else begin
                    left[i] = left[i] - 1;
                    if (left[i] == 1) begin
                        eok[i] = 1; eerr[i] = 0; ed[i] = pq[i]; er[i] = pr[i];
                    end else if (left[i] == 0) begin
                        eok[i] = 0; eerr[i] = 0; ebusy[i] = 0;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("ok32",   {63'd0, ok32},   {63'd0, eok[0]});
        chk("err32",  {63'd0, err32},  {63'd0, eerr[0]});
        chk("busy32", {63'd0, busy32}, {63'd0, ebusy[0]});
        chk("D32",    {32'd0, d32},    ed[0]);
        chk("R32",    {32'd0, r32},    er[0]);
        chk("ok8",    {63'd0, ok8},    {63'd0, eok[1]});
        chk("err8",   {63'd0, err8},   {63'd0, eerr[1]});
        chk("busy8",  {63'd0, busy8},  {63'd0, ebusy[1]});
        chk("D8",     {56'd0, d8},     ed[1]);
        chk("R8",     {56'd0, r8},     er[1]);
    end

    task automatic wait_idle(input int i);
        int n = 0;
        while (left[i] != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 64'(left[i]), 64'd0);
    endtask

    task automatic issue(input int i, input bit sm, input logic [63:0] a, input logic [63:0] b);
        wait_idle(i);
        tst[i] = 1'b1; tsm[i] = sm; ta[i] = a; tbv[i] = b;
        @(posedge clk); #1;
        tst[i] = 1'b0;
        tsm[i] = 1'($urandom);
        ta[i]  = {$urandom, $urandom};
        tbv[i] = {$urandom, $urandom};
    endtask

    task automatic run(input int i, input bit sm, input logic [63:0] a, input logic [63:0] b,
                       output int lat);
        issue(i, sm, a, b);
        lat = 1;
        while (!((i == 0) ? ok32 : ok8) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [63:0] rnd_b(input int sel);
        case (sel)
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'($urandom_range(1, 9));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int lat;
        logic [63:0] q, r, a;
        bit e, f;
        int sel;

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tst[i] = 1'b0; tsm[i] = 1'b0; ta[i] = '0; tbv[i] = '0;
        end

        // Pin the model against hand-computed results.
        model_div(32, 1'b0, 64'd1023, 64'd50, q, r, e, f);
        chk("model_1023_50_q", q, 64'd20);
        chk("model_1023_50_r", r, 64'd23);
        model_div(32, 1'b1, 64'hFFFFFFF9, 64'd2, q, r, e, f);
        chk("model_m7_2_q", q, 64'hFFFFFFFD);
        chk("model_m7_2_r", r, 64'hFFFFFFFF);
        model_div(8, 1'b0, 64'd200, 64'd7, q, r, e, f);
        chk("model_200_7_q", q, 64'd28);
        chk("model_200_7_r", r, 64'd4);
        model_div(32, 1'b1, 64'h80000000, 64'hFFFFFFFF, q, r, e, f);
        chk("model_ovf_q", q, 64'h80000000);
        chk("model_ovf_fast", {63'd0, f}, 64'd1);

        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_D32", {32'd0, d32}, 64'd0);
        chk("reset_busy32", {63'd0, busy32}, 64'd0);

        // Unsigned basic division and latency.
        run(0, 1'b0, 64'd1023, 64'd50, lat);
        chk("t1_lat", 64'(lat), 64'd34);
        chk("t1_D", {32'd0, d32}, 64'd20);
        chk("t1_R", {32'd0, r32}, 64'd23);
        chk("t1_err", {63'd0, err32}, 64'd0);
        @(posedge clk); #1;
        chk("t1_busy_after", {63'd0, busy32}, 64'd0);

        // Signed truncation and remainder sign.
        run(0, 1'b1, 64'hFFFFFFF9, 64'd2, lat);
        chk("t2a_D", {32'd0, d32}, 64'hFFFFFFFD);
        chk("t2a_R", {32'd0, r32}, 64'hFFFFFFFF);
        run(0, 1'b1, 64'd7, 64'hFFFFFFFE, lat);
        chk("t2b_D", {32'd0, d32}, 64'hFFFFFFFD);
        chk("t2b_R", {32'd0, r32}, 64'd1);

        // Divide by zero in both modes, then a normal request.
        run(0, 1'b0, 64'd1234, 64'd0, lat);
        chk("t3u_lat", 64'(lat), 64'd1);
        chk("t3u_err", {63'd0, err32}, 64'd1);
        chk("t3u_D", {32'd0, d32}, 64'hFFFFFFFF);
        chk("t3u_R", {32'd0, r32}, 64'd1234);
        run(0, 1'b1, 64'd1234, 64'd0, lat);
        chk("t3s_lat", 64'(lat), 64'd1);
        chk("t3s_err", {63'd0, err32}, 64'd1);
        chk("t3s_R", {32'd0, r32}, 64'd1234);
        run(0, 1'b0, 64'd1234, 64'd5, lat);
        chk("t3n_err", {63'd0, err32}, 64'd0);
        chk("t3n_D", {32'd0, d32}, 64'd246);
        chk("t3n_R", {32'd0, r32}, 64'd4);

        // Signed overflow, then the same operands unsigned.
        run(0, 1'b1, 64'h80000000, 64'hFFFFFFFF, lat);
        chk("t4s_lat", 64'(lat), 64'd1);
        chk("t4s_D", {32'd0, d32}, 64'h80000000);
        chk("t4s_R", {32'd0, r32}, 64'd0);
        chk("t4s_err", {63'd0, err32}, 64'd0);
        run(0, 1'b0, 64'h80000000, 64'hFFFFFFFF, lat);
        chk("t4u_lat", 64'(lat), 64'd34);
        chk("t4u_D", {32'd0, d32}, 64'd0);
        chk("t4u_R", {32'd0, r32}, 64'h80000000);

        // Reset in the middle of an operation.
        issue(0, 1'b0, 64'd1023, 64'd50);
        repeat (9) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        chk("t5_D", {32'd0, d32}, 64'd0);
        chk("t5_R", {32'd0, r32}, 64'd0);
        chk("t5_ok", {63'd0, ok32}, 64'd0);
        chk("t5_busy", {63'd0, busy32}, 64'd0);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;
        run(0, 1'b0, 64'd100, 64'd7, lat);
        chk("t5b_D", {32'd0, d32}, 64'd14);
        chk("t5b_R", {32'd0, r32}, 64'd2);

        // 8-bit unsigned-only unit, with an ignored start mid-operation.
        wait_idle(1);
        tst[1] = 1'b1; tsm[1] = 1'b1; ta[1] = 64'd200; tbv[1] = 64'd7;
        @(posedge clk); #1;
        tst[1] = 1'b0;
        lat = 1;
        while (!ok8 && lat < 50) begin
            if (lat == 3) begin
                tst[1] = 1'b1; ta[1] = 64'd5; tbv[1] = 64'd1;
            end
            @(posedge clk); #1;
            tst[1] = 1'b0;
            lat++;
        end
        chk("t6_lat", 64'(lat), 64'd10);
        chk("t6_D", {56'd0, d8}, 64'd28);
        chk("t6_R", {56'd0, r8}, 64'd4);

        // start held high: back-to-back operations with operands changing every cycle.
        wait_idle(0);
        tst[0] = 1'b1;
        for (int c = 0; c < 150; c++) begin
            sel = int'($urandom_range(0, 5));
            tsm[0] = 1'($urandom);
            ta[0]  = (sel == 1) ? 64'h80000000 : {$urandom, $urandom};
            tbv[0] = rnd_b(sel);
            @(posedge clk); #1;
        end
        tst[0] = 1'b0;

        // Randomized requests on both units.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                sel = int'($urandom_range(0, 5));
                a = (sel == 1) ? ((i == 0) ? 64'h80000000 : 64'h80) : {$urandom, $urandom};
                issue(i, 1'($urandom), a, rnd_b(sel));
            end
        end

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_param.md
Name: div_param

Overview:
Parametrised sequential integer divider. It is the next generation of the fixed 32-bit div_structural block: configurable width, signed/unsigned mode, a busy flag, deterministic divide-by-zero and signed-overflow results, and single-cycle done/error pulses. It is a radix-2 restoring divider that produces one quotient bit per clock and serves as a shared arithmetic unit behind a start/ok handshake.

Parameters:
WIDTH, 32, operand/result width in bits (legal range 4..64)
SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request; sampled only in IDLE
signed_mode  in  1  1 = two's-complement operands; sampled with start
A  in  WIDTH  dividend; sampled with start
B  in  WIDTH  divisor; sampled with start
D  out  WIDTH  quotient; held until next accepted start
R  out  WIDTH  remainder; held until next accepted start
ok  out  1  one-cycle pulse: D/R valid
err  out  1  one-cycle pulse coincident with ok when B was 0
busy  out  1  high from the cycle after start is accepted until ok is asserted (inclusive)

Behaviour:
- Reset (reset=0, async): state=IDLE; D=0, R=0, ok=0, err=0, busy=0; counter and internal registers cleared. Reset mid-operation aborts; no ok is produced for the aborted request.
- States: IDLE, CALC, FIX, DONE.
- IDLE: when start=1 at a rising edge, latch A, B and the effective mode (signed_mode & SIGNED_EN). Then:
  - B==0 -> DONE with D=all ones, R=A (raw), err=1.
  - else if signed and A==MIN (1 followed by WIDTH-1 zeros) and B==all ones -> DONE with D=MIN, R=0, err=0.
  - else -> CALC with magnitudes |A| and |B| (unsigned mode: raw values), counter=WIDTH, partial remainder=0.
  - busy=1 from this edge.
- CALC: each cycle, shift {rem, quo} left by 1; trial = rem - |B| using a WIDTH+1-bit subtract; if non-negative, rem=trial and the quotient LSB=1, else the quotient LSB=0. Decrement counter; after WIDTH iterations -> FIX.
- FIX (1 cycle): signed mode only: negate the quotient if sign(A)!=sign(B); negate the remainder if A<0. Division truncates toward zero; the remainder carries the dividend's sign; |R|<|B|. Register into D/R -> DONE.
- DONE (1 cycle): ok=1 (err as set above), busy=1; next state IDLE, where busy=0 and ok=err=0.
- Latency (start-accept edge = cycle 0):
  - Normal division: ok high in cycle WIDTH+2 (34 for WIDTH=32).
  - Divide-by-zero and overflow cases: ok high in cycle 1.
- start=1 while not IDLE is ignored; the operation in flight is not disturbed.
- start held high continuously: a new request is accepted in the first IDLE cycle after DONE, i.e. back-to-back operations every WIDTH+3 cycles.
- A/B/signed_mode changes after acceptance have no effect.
- D/R keep the last results while idle; they are overwritten only in FIX, or at the DONE entry for the special cases.

Test Plan:
1. WIDTH=32, unsigned: A=1023, B=50, start=1 after reset release -> ok pulse at cycle 34; D=20, R=23, err=0; busy low on the following cycle.
2. Signed: A=-7 (0xFFFFFFF9), B=2 -> D=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1). Also A=7, B=-2 -> D=-3, R=1.
3. Divide by zero: A=1234, B=0, both modes -> ok and err pulse at cycle 1; D=0xFFFFFFFF, R=1234. The next request with B=5 completes with err=0.
4. Signed overflow: A=0x80000000, B=0xFFFFFFFF, signed_mode=1 -> ok at cycle 1; D=0x80000000, R=0, err=0. The same operands with signed_mode=0 -> D=0, R=0x80000000 after 34 cycles.
5. Reset mid-operation: start A=1023, B=50; drive reset low at cycle 10 -> D/R/ok/busy go 0 immediately with no ok pulse. After release, start A=100, B=7 -> D=14, R=2.
6. WIDTH=8, SIGNED_EN=0: A=200, B=7, signed_mode=1 -> treated as unsigned; D=28, R=4, ok at cycle 10. A start pulse at cycle 4 is ignored.
